fir_pingpong_buf: RTL and testbench

//  Ping-pong sample buffer sitting directly downstream of the FIR input dmux_1to2.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_bank_ram.sv | 37 +++
 rtl/fir_pingpong_buf.sv | 206 ++++++++++++++++++++
 tb/tb_fir_pingpong_buf.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Purpose: shared types for the FIR input ping-pong buffer (sample width, bank index, read FSM state).
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package fir_pkg;

    localparam int FIR_N = 16;

    typedef logic [FIR_N-1:0] sample_t;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    function automatic bank_t other_bank(input bank_t b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/fir_bank_ram.sv
// Purpose: one DEPTH x N sample bank with a write port and a registered, enabled read port.
// Latency: read data appears on rdata one clock after re is sampled high.
// Backpressure: none; rdata holds its last value while re is low.
//
// Ports:
//   clk          clock
//   we/waddr/wdata  write port
//   re/raddr     read enable and address; rdata is the registered read word
// Contents and rdata are intentionally not reset.
module fir_bank_ram
    import fir_pkg::*;
#(
    parameter int N     = FIR_N,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fir_pingpong_buf.sv
// Purpose: ping-pong buffer behind the FIR input demux; fills one bank while streaming the other to the MAC.
// Latency: rd_valid rises one clock after a bank's full flag sets; then one sample per clock.
// Backpressure: in_ready drops while the write bank is full; rd_data/rd_last/rd_bank hold while rd_ready is low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   write handshake for the sample at the demux input
//   bank_sel              demux select: 0 -> A / bank0, 1 -> B / bank1
//   a_in, b_in            demux outputs A and B
//   rd_valid / rd_ready   read handshake towards the FIR engine
//   rd_data, rd_last      current sample and end-of-bank marker
//   rd_bank               bank currently being drained
module fir_pingpong_buf
    import fir_pkg::*;
#(
    parameter int N     = FIR_N,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         bank_sel,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [N-1:0] rd_data,
    output logic         rd_last,
    output logic         rd_bank
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // write side
    bank_t         wr_bank_q;
    logic [AW-1:0] wr_ptr_q;
    logic          wr_accept;
    logic          wr_wrap;
    logic [N-1:0]  wr_data;

    // bank status
    logic [1:0]    full_q;
    logic [1:0]    full_d;

    // read side
    rd_state_t     state_q, state_d;
    bank_t         rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_last_q, rd_last_d;
    logic          rd_release;
    logic          load;
    bank_t         load_bank;
    logic [AW-1:0] load_addr;

    logic [N-1:0]  q0, q1;

    // ------------------------------------------------------------------
    // Write side: in_ready looks only at the registered full flag, so a
    // bank that is released this cycle cannot be written until the next.
    // ------------------------------------------------------------------
    assign in_ready  = !full_q[wr_bank_q];
    assign wr_accept = in_valid && in_ready;
    assign wr_wrap   = wr_accept && (wr_ptr_q == LAST);
    assign wr_data   = (wr_bank_q == BANK1) ? b_in : a_in;
    assign bank_sel  = wr_bank_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= BANK0;
            wr_ptr_q  <= '0;
        end else if (wr_accept) begin
            // DEPTH is a power of two, so the pointer wraps to 0 naturally
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (wr_ptr_q == LAST) begin
                wr_bank_q <= other_bank(wr_bank_q);
            end
        end
    end

    // A completed write and a released read always target different banks,
    // so both updates can be applied independently in the same cycle.
    always_comb begin
        full_d = full_q;
        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_wrap) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM. 'load' fetches the next sample into the selected bank's
    // registered read port, so the RAM output register doubles as the
    // rd_data output register.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        rd_ptr_d   = rd_ptr_q;
        rd_last_d  = rd_last_q;
        rd_release = 1'b0;
        load       = 1'b0;
        load_bank  = rd_bank_q;
        load_addr  = rd_ptr_q;

        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = READ;
                    rd_ptr_d  = '0;
                    rd_last_d = 1'b0;
                    load      = 1'b1;
                    load_addr = '0;
                end
            end
            READ: begin
                if (rd_ready) begin
                    if (rd_ptr_q == LAST) begin
                        rd_release = 1'b1;
                        rd_bank_d  = other_bank(rd_bank_q);
                        rd_ptr_d   = '0;
                        rd_last_d  = 1'b0;
                        if (full_q[other_bank(rd_bank_q)]) begin
                            // back-to-back banks: no bubble between them
                            load      = 1'b1;
                            load_bank = other_bank(rd_bank_q);
                            load_addr = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                        rd_last_d = (rd_ptr_d == LAST);
                        load      = 1'b1;
                        load_addr = rd_ptr_d;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_bank_q <= BANK0;
            rd_ptr_q  <= '0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_last_q <= rd_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Banks
    // ------------------------------------------------------------------
    fir_bank_ram #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_bank0 (
        .clk   (clk),
        .we    (wr_accept && (wr_bank_q == BANK0)),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (load && (load_bank == BANK0)),
        .raddr (load_addr),
        .rdata (q0)
    );

    fir_bank_ram #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_bank1 (
        .clk   (clk),
        .we    (wr_accept && (wr_bank_q == BANK1)),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (load && (load_bank == BANK1)),
        .raddr (load_addr),
        .rdata (q1)
    );

    // The RAM output registers are not reset; gating with rd_valid gives
    // rd_data a defined zero whenever no sample is being presented.
    assign rd_valid = (state_q == READ);
    assign rd_bank  = rd_bank_q;
    assign rd_last  = rd_last_q;
    assign rd_data  = rd_valid ? ((rd_bank_q == BANK1) ? q1 : q0) : '0;

endmodule

// File: tb/tb_fir_pingpong_buf.sv
// Purpose: directed self-checking bench for fir_pingpong_buf with a behavioural dmux in front.
// Latency: checks rd_valid one clock after a bank fills, one sample per clock thereafter.
// Backpressure: exercises full-bank write stalls and rd_ready stalls.
module tb_fir_pingpong_buf;
    import fir_pkg::*;

    localparam int N     = 16;
    localparam int DEPTH = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         in_valid = 1'b0;
    logic         rd_ready = 1'b0;
    logic [N-1:0] din      = '0;

    logic         in_ready;
    logic         bank_sel;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         rd_valid;
    logic [N-1:0] rd_data;
    logic         rd_last;
    logic         rd_bank;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // dmux_1to2 model: the unselected output is driven to zero
    assign a_in = (in_valid && (bank_sel == 1'b0)) ? din : '0;
    assign b_in = (in_valid && (bank_sel == 1'b1)) ? din : '0;

    fir_pingpong_buf #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bank_sel (bank_sel),
        .a_in     (a_in),
        .b_in     (b_in),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .rd_bank  (rd_bank)
    );

    // handshake recorders, sampled on the falling edge
    typedef struct packed {
        logic         bank;
        logic         last;
        logic [N-1:0] data;
    } rd_rec_t;

    rd_rec_t      rdq[$];
    logic [N:0]   acq[$];

    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) rdq.push_back({rd_bank, rd_last, rd_data});
        if (rst_n && in_valid && in_ready) acq.push_back({bank_sel, din});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rd_ready = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    // present one sample and hold it until accepted
    task automatic put(input logic [N-1:0] v);
        int n = 0;
        din      = v;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("put_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int      base_rd;
        int      base_ac;
        int      n;
        int      idx;
        int      c;
        logic [3:0] pat;
        rd_rec_t exp_rec;

        // ---------------- 1: asynchronous reset mid-cycle ----------------
        #3 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_bank_sel", 32'(bank_sel), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        chk("rst_rd_bank",  32'(rd_bank),  32'd0);
        chk("rst_rd_last",  32'(rd_last),  32'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // ---------------- 2: bank0 fill and drain ----------------
        rd_ready = 1'b1;
        for (int i = 1; i <= 8; i++) put(16'(i));
        chk("t2_bank_sel", 32'(bank_sel), 32'd1);
        chk("t2_valid_lag", 32'(rd_valid), 32'd0);
        chk("t2_in_ready", 32'(in_ready), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t2_valid", 32'(rd_valid), 32'd1);
            chk("t2_data",  32'(rd_data),  32'(i));
            chk("t2_last",  32'(rd_last),  32'(i == 8));
            chk("t2_bank",  32'(rd_bank),  32'd0);
        end
        tick();
        chk("t2_idle", 32'(rd_valid), 32'd0);

        // ---------------- 3: both banks full, backpressure ----------------
        do_reset();
        base_rd = rdq.size();
        base_ac = acq.size();
        for (int i = 1; i <= 16; i++) put(16'(i));
        chk("t3_in_ready_full", 32'(in_ready), 32'd0);
        chk("t3_bank_sel",      32'(bank_sel), 32'd0);
        chk("t3_valid_held",    32'(rd_valid), 32'd1);
        chk("t3_data_held",     32'(rd_data),  32'd1);
        chk("t3_bank_held",     32'(rd_bank),  32'd0);
        din      = 16'd99;
        in_valid = 1'b1;
        repeat (3) tick();
        chk("t3_dropped", 32'(acq.size() - base_ac), 32'd16);
        chk("t3_still_full", 32'(in_ready), 32'd0);
        rd_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("t3_released", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        repeat (12) tick();
        chk("t3_nrd", 32'(rdq.size() - base_rd), 32'd16);
        for (int i = 0; i < 16; i++) begin
            exp_rec = {(i >= 8), (i == 7 || i == 15), 16'(i + 1)};
            if (base_rd + i < rdq.size()) chk("t3_rec", 32'(rdq[base_rd + i]), 32'(exp_rec));
        end
        chk("t3_nacc", 32'(acq.size() - base_ac), 32'd17);
        if (acq.size() > 0) chk("t3_acc99", 32'(acq[acq.size() - 1]), 32'd99);
        chk("t3_idle", 32'(rd_valid), 32'd0);
        chk("t3_bank_sel_after", 32'(bank_sel), 32'd0);

        // ---------------- 4: no bubble between banks ----------------
        do_reset();
        rd_ready = 1'b1;
        for (int i = 1; i <= 16; i++) put(16'(i));
        chk("t4_valid8", 32'(rd_valid), 32'd1);
        chk("t4_data8",  32'(rd_data),  32'd8);
        chk("t4_last8",  32'(rd_last),  32'd1);
        chk("t4_bank8",  32'(rd_bank),  32'd0);
        for (int i = 9; i <= 16; i++) begin
            tick();
            chk("t4_valid", 32'(rd_valid), 32'd1);
            chk("t4_data",  32'(rd_data),  32'(i));
            chk("t4_bank",  32'(rd_bank),  32'd1);
            chk("t4_last",  32'(rd_last),  32'(i == 16));
        end
        tick();
        chk("t4_idle", 32'(rd_valid), 32'd0);

        // ---------------- 5: rd_ready stall pattern 1,0,0,1 ----------------
        do_reset();
        for (int i = 1; i <= 8; i++) put(16'(i));
        tick();
        chk("t5_valid_rise", 32'(rd_valid), 32'd1);
        pat = 4'b1001;
        idx = 1;
        c   = 0;
        while (idx <= 8 && c < 40) begin
            rd_ready = pat[c % 4];
            chk("t5_valid", 32'(rd_valid), 32'd1);
            chk("t5_data",  32'(rd_data),  32'(idx));
            chk("t5_last",  32'(rd_last),  32'(idx == 8));
            tick();
            if (rd_ready) idx++;
            c++;
        end
        chk("t5_count", 32'(idx), 32'd9);
        chk("t5_idle", 32'(rd_valid), 32'd0);

        // ---------------- 6: reset in the middle of a fill ----------------
        do_reset();
        rd_ready = 1'b1;
        for (int i = 1; i <= 5; i++) put(16'(50 + i));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_bank_sel", 32'(bank_sel), 32'd0);
        chk("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        for (int i = 21; i <= 28; i++) put(16'(i));
        chk("t6_bank_sel", 32'(bank_sel), 32'd1);
        for (int i = 21; i <= 28; i++) begin
            tick();
            chk("t6_valid", 32'(rd_valid), 32'd1);
            chk("t6_data",  32'(rd_data),  32'(i));
            chk("t6_bank",  32'(rd_bank),  32'd0);
            chk("t6_last",  32'(rd_last),  32'(i == 28));
        end
        tick();
        chk("t6_idle", 32'(rd_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
